// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetcher: pulls opcode and operand bytes from a
// byte-wide memory, packs them into ope/ope_ext and presents the finished
// instruction to decode/ALU over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_OP   | requesting the opcode byte at mem_addr
// S_ARG  | requesting the remaining operand bytes of the instruction
// S_OUT  | instruction presented (ope_valid=1), waiting for ope_ready
// S_ILL  | unsupported opcode seen; stalled until branch or reset
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_EIP  = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_req,
   input  logic                  mem_ack,
   input  logic [7:0]            mem_data,
   output logic [31:0]           ope,
   output logic [7:0]            ope_ext,
   output logic [2:0]            ope_len,
   output logic                  ope_valid,
   input  logic                  ope_ready,
   output logic [ADDR_WIDTH-1:0] eip,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  illegal
);

   typedef enum logic [1:0] {
      S_OP  = 2'd0,
      S_ARG = 2'd1,
      S_OUT = 2'd2,
      S_ILL = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   mem_addr_n;
   logic                    mem_req_n;
   logic [31:0]             ope_n;
   logic [7:0]              ope_ext_n;
   logic [2:0]              ope_len_n;
   logic                    ope_valid_n;
   logic [ADDR_WIDTH-1:0]   eip_n;
   logic                    illegal_n;
   logic [2:0]              byte_idx, byte_idx_n;
   logic                    capture;
   logic [2:0]              dec_len;

   // Opcode length table; 0 marks an unsupported opcode.
   function automatic logic [2:0] op_len(input logic [7:0] op);
      case (op)
         8'h55, 8'h5d, 8'hc3: op_len = 3'd1;
         8'h89:               op_len = 3'd2;
         8'hb8, 8'he8:        op_len = 3'd5;
         default:             op_len = 3'd0;
      endcase
   endfunction

   assign capture = mem_req & mem_ack;
   assign dec_len = op_len(mem_data);

   // Next-state and next-output computation; branch overrides every state.
   always_comb begin
      state_n     = state;
      mem_addr_n  = mem_addr;
      mem_req_n   = mem_req;
      ope_n       = ope;
      ope_ext_n   = ope_ext;
      ope_len_n   = ope_len;
      ope_valid_n = ope_valid;
      eip_n       = eip;
      illegal_n   = illegal;
      byte_idx_n  = byte_idx;

      if (branch_valid) begin
         // Any in-flight byte ack and any held instruction are dropped.
         state_n     = S_OP;
         mem_addr_n  = branch_target;
         mem_req_n   = 1'b1;
         ope_n       = '0;
         ope_ext_n   = '0;
         ope_len_n   = '0;
         ope_valid_n = 1'b0;
         illegal_n   = 1'b0;
         byte_idx_n  = '0;
      end else begin
         case (state)
            S_OP: begin
               mem_req_n = 1'b1;
               if (capture) begin
                  mem_addr_n = mem_addr + ADDR_ONE;
                  eip_n      = mem_addr;
                  ope_n      = {mem_data, 24'h00_0000};
                  ope_ext_n  = '0;
                  ope_len_n  = dec_len;
                  byte_idx_n = 3'd1;
                  if (dec_len == 3'd0) begin
                     state_n   = S_ILL;
                     mem_req_n = 1'b0;
                     illegal_n = 1'b1;
                  end else if (dec_len == 3'd1) begin
                     state_n     = S_OUT;
                     mem_req_n   = 1'b0;
                     ope_valid_n = 1'b1;
                  end else begin
                     state_n = S_ARG;
                  end
               end
            end
            S_ARG: begin
               mem_req_n = 1'b1;
               if (capture) begin
                  mem_addr_n = mem_addr + ADDR_ONE;
                  byte_idx_n = byte_idx + 3'd1;
                  case (byte_idx)
                     3'd1:    ope_n[23:16] = mem_data;
                     3'd2:    ope_n[15:8]  = mem_data;
                     3'd3:    ope_n[7:0]   = mem_data;
                     3'd4:    ope_ext_n    = mem_data;
                     default: ope_n        = ope;
                  endcase
                  if (byte_idx + 3'd1 == ope_len) begin
                     state_n     = S_OUT;
                     mem_req_n   = 1'b0;
                     ope_valid_n = 1'b1;
                  end
               end
            end
            S_OUT: begin
               mem_req_n   = 1'b0;
               ope_valid_n = 1'b1;
               // mem_addr already sits at eip + ope_len, the next opcode.
               if (ope_ready) begin
                  state_n     = S_OP;
                  mem_req_n   = 1'b1;
                  ope_valid_n = 1'b0;
               end
            end
            S_ILL: begin
               mem_req_n   = 1'b0;
               ope_valid_n = 1'b0;
               illegal_n   = 1'b1;
            end
            default: begin
               state_n   = S_OP;
               mem_req_n = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; synchronous reset drops everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_OP;
         mem_addr  <= RESET_EIP;
         mem_req   <= 1'b0;
         ope       <= '0;
         ope_ext   <= '0;
         ope_len   <= '0;
         ope_valid <= 1'b0;
         eip       <= RESET_EIP;
         illegal   <= 1'b0;
         byte_idx  <= '0;
      end else begin
         state     <= state_n;
         mem_addr  <= mem_addr_n;
         mem_req   <= mem_req_n;
         ope       <= ope_n;
         ope_ext   <= ope_ext_n;
         ope_len   <= ope_len_n;
         ope_valid <= ope_valid_n;
         eip       <= eip_n;
         illegal   <= illegal_n;
         byte_idx  <= byte_idx_n;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: zero-wait byte memory, scoreboard of expected
// instructions compared at each accepted handshake, plus direct checks.
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, eip, branch_target;
   logic        mem_req, mem_ack, ope_valid, ope_ready, branch_valid, illegal;
   logic [7:0]  mem_data, ope_ext;
   logic [31:0] ope;
   logic [2:0]  ope_len;

   logic [31:0] mem_addr2, eip2;
   logic        mem_req2, ope_valid2, ope_ready2, illegal2;
   logic [7:0]  mem_data2, ope_ext2;
   logic [31:0] ope2;
   logic [2:0]  ope_len2;

   logic [7:0]  mem [0:511];

   typedef struct packed {
      logic [31:0] ope;
      logic [7:0]  ext;
      logic [2:0]  len;
      logic [31:0] eip;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n;

   always #5 clock = ~clock;

   assign mem_ack   = 1'b1;
   assign mem_data  = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 8'h90;
   assign mem_data2 = (mem_addr2 == 32'hFFFF_FFFE) ? 8'h89 :
                      (mem_addr2 == 32'hFFFF_FFFF) ? 8'he5 : 8'h90;

   instruction_fetch #(.ADDR_WIDTH(32), .RESET_EIP(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_data(mem_data), .ope(ope), .ope_ext(ope_ext),
      .ope_len(ope_len), .ope_valid(ope_valid), .ope_ready(ope_ready),
      .eip(eip), .branch_valid(branch_valid), .branch_target(branch_target),
      .illegal(illegal));

   instruction_fetch #(.ADDR_WIDTH(32), .RESET_EIP(32'hFFFF_FFFE)) dut2 (
      .clock(clock), .reset(reset), .mem_addr(mem_addr2), .mem_req(mem_req2),
      .mem_ack(mem_ack), .mem_data(mem_data2), .ope(ope2), .ope_ext(ope_ext2),
      .ope_len(ope_len2), .ope_valid(ope_valid2), .ope_ready(ope_ready2),
      .eip(eip2), .branch_valid(1'b0), .branch_target(32'h0),
      .illegal(illegal2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] o, input logic [7:0] x, input logic [2:0] l,
                       input logic [31:0] e);
      exp_t t;
      t.ope = o; t.ext = x; t.len = l; t.eip = e;
      exp_q.push_back(t);
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!ope_valid && cycles < budget);
      if (!ope_valid) check("wait_valid_timeout", 64'(ope_valid), 64'd1);
   endtask

   // Scoreboard: each accepted handshake pops the oldest expected instruction.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && ope_valid && ope_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ope", {32'h0, ope}, 64'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            check("sb_ope", 64'(ope), 64'(e.ope));
            check("sb_ext", 64'(ope_ext), 64'(e.ext));
            check("sb_len", 64'(ope_len), 64'(e.len));
            check("sb_eip", 64'(eip), 64'(e.eip));
         end
      end
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h90;
      mem[0] = 8'h55;
      mem[1] = 8'hb8; mem[2] = 8'h78; mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
      mem[6] = 8'h89; mem[7] = 8'he5;
      mem[8] = 8'he8; mem[9] = 8'h11; mem[10] = 8'h22; mem[11] = 8'h33; mem[12] = 8'h44;
      mem[9'h100] = 8'h55; mem[9'h101] = 8'h55; mem[9'h102] = 8'h90;

      reset = 1'b1; ope_ready = 1'b0; ope_ready2 = 1'b0;
      branch_valid = 1'b0; branch_target = 32'h0;
      repeat (3) step();
      check("rst_ope", 64'(ope), 64'h0);
      check("rst_valid", 64'(ope_valid), 64'h0);
      check("rst_req", 64'(mem_req), 64'h0);
      check("rst_addr", 64'(mem_addr), 64'h0);
      check("rst_eip", 64'(eip), 64'h0);
      check("rst_illegal", 64'(illegal), 64'h0);
      check("rst_len", 64'(ope_len), 64'h0);

      // 1: single-byte opcode right after reset
      push(32'h5500_0000, 8'h00, 3'd1, 32'h0);
      push(32'hb878_5634, 8'h12, 3'd5, 32'h1);
      reset = 1'b0;
      step();
      check("t1_req_rise", 64'(mem_req), 64'h1);
      check("t1_valid_lo", 64'(ope_valid), 64'h0);
      step();
      check("t1_valid", 64'(ope_valid), 64'h1);
      check("t1_ope", 64'(ope), 64'h5500_0000);
      check("t1_len", 64'(ope_len), 64'h1);
      check("t1_eip", 64'(eip), 64'h0);
      check("t1_req_lo", 64'(mem_req), 64'h0);
      step();
      check("t1_req_hold", 64'(mem_req), 64'h0);
      ope_ready = 1'b1;

      // 2: five-byte instruction, zero-wait, ready high
      wait_valid(20, n);
      check("t2_latency", 64'(n), 64'd6);
      check("t2_next_addr", 64'(mem_addr), 64'h6);

      // 3: two-byte instruction held with ready low
      push(32'h89e5_0000, 8'h00, 3'd2, 32'h6);
      step();
      ope_ready = 1'b0;
      wait_valid(20, n);
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_ope", 64'(ope), 64'h89e5_0000);
         check("t3_hold_valid", 64'(ope_valid), 64'h1);
         check("t3_hold_req", 64'(mem_req), 64'h0);
         step();
      end
      ope_ready = 1'b1;
      step();
      check("t3_after_valid", 64'(ope_valid), 64'h0);
      check("t3_after_req", 64'(mem_req), 64'h1);
      check("t3_after_addr", 64'(mem_addr), 64'h8);

      // 4: branch on the third byte of a partial e8
      step();
      step();
      check("t4_pre_addr", 64'(mem_addr), 64'd10);
      push(32'h5500_0000, 8'h00, 3'd1, 32'h100);
      branch_valid = 1'b1; branch_target = 32'h100;
      step();
      branch_valid = 1'b0;
      check("t4_br_addr", 64'(mem_addr), 64'h100);
      check("t4_br_valid", 64'(ope_valid), 64'h0);
      check("t4_br_req", 64'(mem_req), 64'h1);
      wait_valid(10, n);
      push(32'h5500_0000, 8'h00, 3'd1, 32'h101);
      wait_valid(10, n);
      check("t4_latency_1byte", 64'(n), 64'd2);

      // 5: unsupported opcode, then branch back to 0
      n = 0;
      do begin
         step();
         n++;
      end while (!illegal && n < 10);
      check("t5_illegal", 64'(illegal), 64'h1);
      for (int i = 0; i < 4; i++) begin
         check("t5_ill_hold", 64'(illegal), 64'h1);
         check("t5_ill_req", 64'(mem_req), 64'h0);
         check("t5_ill_valid", 64'(ope_valid), 64'h0);
         step();
      end
      push(32'h5500_0000, 8'h00, 3'd1, 32'h0);
      branch_valid = 1'b1; branch_target = 32'h0;
      step();
      branch_valid = 1'b0;
      check("t5_br_illegal", 64'(illegal), 64'h0);
      check("t5_br_req", 64'(mem_req), 64'h1);
      check("t5_br_addr", 64'(mem_addr), 64'h0);
      wait_valid(10, n);
      step();

      // 6: wrap-around instance has been presenting 89 e5 since reset release
      check("t6_valid", 64'(ope_valid2), 64'h1);
      check("t6_ope", 64'(ope2), 64'h89e5_0000);
      check("t6_eip", 64'(eip2), 64'hFFFF_FFFE);
      check("t6_len", 64'(ope_len2), 64'h2);
      ope_ready2 = 1'b1;
      step();
      ope_ready2 = 1'b0;
      check("t6_wrap_addr", 64'(mem_addr2), 64'h0);
      check("t6_after_valid", 64'(ope_valid2), 64'h0);

      // reset in the middle of a fetch discards everything
      ope_ready = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("mid_rst_valid", 64'(ope_valid), 64'h0);
      check("mid_rst_req", 64'(mem_req), 64'h0);
      check("mid_rst_addr", 64'(mem_addr), 64'h0);
      check("mid_rst_ope", 64'(ope), 64'h0);
      reset = 1'b0;
      step();
      check("mid_rst_req_rise", 64'(mem_req), 64'h1);

      check("sb_empty", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
